// File: rtl/uart_char_rx_pkg.sv
// Shared types and helpers for the UART character receiver.
// Holds the receiver state encoding and the bit-period calculation.
package uart_char_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state;

    function automatic int unsigned calc_bit_ticks(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte buffer with valid/ready pop side.
// Overflow pulses for one cycle when a push is dropped while full.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push_in,
    input  logic [7:0] push_data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       overflow_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, do_push;

    // Head is read straight from registered storage.
    assign valid_out    = (count_q != '0);
    assign data_out     = mem_q[rd_ptr_q];
    assign overflow_out = ovf_q;

    // Pointer and occupancy update; a pop frees room for a same-cycle push.
    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = valid_out && ready_in;
        do_push  = push_in && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_in && full && !pop;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    // Pointer, count and overflow pulse registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 UART receiver feeding a byte FIFO for the command parser.
// Mid-bit sampling; reception never stalls on consumer backpressure.
module uart_char_rx
    import uart_char_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] char_out,
    output logic       char_out_valid,
    input  logic       char_out_ready,
    output logic       frame_err_out,
    output logic       overflow_out
);

    localparam int unsigned BIT_TICKS  = calc_bit_ticks(CLK_HZ, BAUD);
    localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
    localparam int unsigned CNT_W =
        (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

    uart_rx_state     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       sync_q, sync_d;
    logic             ferr_q, ferr_d;
    logic             push;
    logic             rx_s;

    assign sync_d        = {sync_q[0], rx_in};
    assign rx_s          = sync_q[1];
    assign frame_err_out = ferr_q;

    // Frame decoder: find start edge, sample each bit at its centre.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Receiver state, synchronizer and error pulse registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sync_q  <= 2'b11;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sync_q  <= sync_d;
            ferr_q  <= ferr_d;
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_in     (push),
        .push_data_in(shift_q),
        .data_out    (char_out),
        .valid_out   (char_out_valid),
        .ready_in    (char_out_ready),
        .overflow_out(overflow_out)
    );

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed testbench for uart_char_rx.
// Bit period shortened to 64 clocks so the whole run stays short.
module tb_uart_char_rx;
    import uart_char_rx_pkg::*;

    localparam int BT   = 64;
    localparam int HALF = 32;

    logic       clk;
    logic       rst_in;
    logic       rx_in;
    logic [7:0] char_out;
    logic       char_out_valid;
    logic       char_out_ready;
    logic       frame_err_out;
    logic       overflow_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         valid_hi = 0;
    int         ferr_hi = 0;
    int         ovf_hi = 0;

    uart_char_rx #(
        .CLK_HZ    (100_000_000),
        .BAUD      (1_562_500),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rx_in         (rx_in),
        .char_out      (char_out),
        .char_out_valid(char_out_valid),
        .char_out_ready(char_out_ready),
        .frame_err_out (frame_err_out),
        .overflow_out  (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted bytes and pulse activity between edges.
    always @(negedge clk) begin
        if (char_out_valid) valid_hi <= valid_hi + 1;
        if (frame_err_out) ferr_hi <= ferr_hi + 1;
        if (overflow_out) ovf_hi <= ovf_hi + 1;
        if (char_out_valid && char_out_ready) begin
            got_data.push_back(char_out);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; optionally raise ready only on the push cycle.
    task automatic send_byte(input logic [7:0] d, input logic stop,
                             input bit pulse_ready, output int c0);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        tick(1);
        c0 = cyc;
        for (int i = 0; i < 10 * BT; i++) begin
            if (i > 0) tick(1);
            rx_in = fr[i / BT];
            if (pulse_ready)
                char_out_ready = (cyc == c0 + 2 + HALF + 9 * BT);
        end
        tick(1);
        rx_in = 1'b1;
        if (pulse_ready) char_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        rx_in = 1'b1;
        char_out_ready = 1'b0;
        tick(5);
        checks++;
        if (char_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", char_out_valid);
        end
        checks++;
        if (frame_err_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr: got %b expected 0", frame_err_out);
        end
        checks++;
        if (overflow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", overflow_out);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d",
                     dut.state_q, IDLE);
        end
        rst_in = 1'b1;
        tick(4);
    endtask

    task automatic test_single_char;
        int bp, bv, bf, bo, c0, ex;
        char_out_ready = 1'b1;
        bp = got_data.size();
        bv = valid_hi;
        bf = ferr_hi;
        bo = ovf_hi;
        send_byte(8'h67, 1'b1, 1'b0, c0);
        tick(8);
        ex = c0 + 3 + HALF + 9 * BT;
        checks++;
        if (got_data.size() - bp !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1",
                     got_data.size() - bp);
        end
        checks++;
        if (got_data.size() <= bp || got_data[bp] !== 8'h67) begin
            errors++;
            $display("FAIL single_data: got %h expected 67",
                     (got_data.size() > bp) ? got_data[bp] : 8'hxx);
        end
        checks++;
        if (got_cyc.size() <= bp || got_cyc[bp] < ex
            || got_cyc[bp] > ex + 1) begin
            errors++;
            $display("FAIL single_latency: got cycle %0d expected %0d",
                     (got_cyc.size() > bp) ? got_cyc[bp] : -1, ex);
        end
        checks++;
        if (valid_hi - bv !== 1) begin
            errors++;
            $display("FAIL single_valid_len: got %0d expected 1",
                     valid_hi - bv);
        end
        checks++;
        if (ferr_hi - bf !== 0 || ovf_hi - bo !== 0) begin
            errors++;
            $display("FAIL single_pulses: got ferr %0d ovf %0d expected 0 0",
                     ferr_hi - bf, ovf_hi - bo);
        end
    endtask

    task automatic test_glitch;
        int bp, bf, bo;
        char_out_ready = 1'b1;
        bp = got_data.size();
        bf = ferr_hi;
        bo = ovf_hi;
        rx_in = 1'b0;
        tick(20);
        rx_in = 1'b1;
        tick(2 * BT);
        checks++;
        if (got_data.size() - bp !== 0) begin
            errors++;
            $display("FAIL glitch_push: got %0d bytes expected 0",
                     got_data.size() - bp);
        end
        checks++;
        if (ferr_hi - bf !== 0 || ovf_hi - bo !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got ferr %0d ovf %0d expected 0 0",
                     ferr_hi - bf, ovf_hi - bo);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d expected %0d",
                     dut.state_q, IDLE);
        end
    endtask

    task automatic test_frame_error;
        int bp, bf, c0;
        char_out_ready = 1'b1;
        bp = got_data.size();
        bf = ferr_hi;
        send_byte(8'h55, 1'b0, 1'b0, c0);
        tick(2 * BT);
        checks++;
        if (ferr_hi - bf !== 1) begin
            errors++;
            $display("FAIL ferr_pulse: got %0d cycles expected 1",
                     ferr_hi - bf);
        end
        checks++;
        if (got_data.size() - bp !== 0 || char_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_empty: got %0d bytes valid %b expected 0 0",
                     got_data.size() - bp, char_out_valid);
        end
        send_byte(8'h0A, 1'b1, 1'b0, c0);
        tick(8);
        checks++;
        if (got_data.size() - bp !== 1 || got_data[bp] !== 8'h0A) begin
            errors++;
            $display("FAIL ferr_recover: got %0d bytes expected one 0a",
                     got_data.size() - bp);
        end
        checks++;
        if (ferr_hi - bf !== 1) begin
            errors++;
            $display("FAIL ferr_recover_pulse: got %0d expected 1",
                     ferr_hi - bf);
        end
    endtask

    task automatic test_overflow;
        int bp, bo, c0;
        char_out_ready = 1'b0;
        bp = got_data.size();
        bo = ovf_hi;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0, c0);
        tick(4);
        checks++;
        if (ovf_hi - bo !== 0) begin
            errors++;
            $display("FAIL ovf_early: got %0d expected 0", ovf_hi - bo);
        end
        send_byte(8'h10, 1'b1, 1'b0, c0);
        tick(4);
        checks++;
        if (ovf_hi - bo !== 1) begin
            errors++;
            $display("FAIL ovf_pulse: got %0d expected 1", ovf_hi - bo);
        end
        checks++;
        if (dut.u_fifo.count_q !== 5'd16) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 16",
                     dut.u_fifo.count_q);
        end
        char_out_ready = 1'b1;
        tick(24);
        checks++;
        if (got_data.size() - bp !== 16) begin
            errors++;
            $display("FAIL ovf_drain_n: got %0d expected 16",
                     got_data.size() - bp);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_data.size() <= bp + i || got_data[bp + i] !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", i,
                         (got_data.size() > bp + i) ? got_data[bp + i] : 8'hxx,
                         8'(i));
            end
        end
        checks++;
        if (char_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got %b expected 0", char_out_valid);
        end
    endtask

    task automatic test_full_push_pop;
        int bp, bo, c0;
        logic [7:0] ex;
        char_out_ready = 1'b0;
        bo = ovf_hi;
        for (int i = 0; i < 16; i++)
            send_byte(8'h20 + 8'(i), 1'b1, 1'b0, c0);
        tick(4);
        checks++;
        if (dut.u_fifo.count_q !== 5'd16) begin
            errors++;
            $display("FAIL full_fill: got %0d expected 16",
                     dut.u_fifo.count_q);
        end
        bp = got_data.size();
        send_byte(8'h41, 1'b1, 1'b1, c0);
        tick(4);
        checks++;
        if (ovf_hi - bo !== 0) begin
            errors++;
            $display("FAIL full_ovf: got %0d expected 0", ovf_hi - bo);
        end
        checks++;
        if (dut.u_fifo.count_q !== 5'd16) begin
            errors++;
            $display("FAIL full_count: got %0d expected 16",
                     dut.u_fifo.count_q);
        end
        checks++;
        if (got_data.size() - bp !== 1 || got_data[bp] !== 8'h20) begin
            errors++;
            $display("FAIL full_pop: got %0d bytes expected one 20",
                     got_data.size() - bp);
        end
        bp = got_data.size();
        char_out_ready = 1'b1;
        tick(24);
        for (int i = 0; i < 16; i++) begin
            ex = (i < 15) ? 8'h21 + 8'(i) : 8'h41;
            checks++;
            if (got_data.size() <= bp + i || got_data[bp + i] !== ex) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h expected %h", i,
                         (got_data.size() > bp + i) ? got_data[bp + i] : 8'hxx,
                         ex);
            end
        end
        checks++;
        if (char_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got %b expected 0", char_out_valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        int bp, bf, c0;
        logic [9:0] fr;
        logic [7:0] exp_q[3];
        exp_q = '{8'h67, 8'h6F, 8'h0A};
        fr = {1'b1, 8'h70, 1'b0};
        char_out_ready = 1'b1;
        bp = got_data.size();
        bf = ferr_hi;
        tick(1);
        for (int i = 0; i < 5 * BT + HALF; i++) begin
            rx_in = fr[i / BT];
            tick(1);
        end
        rst_in = 1'b0;
        rx_in = 1'b1;
        tick(4);
        checks++;
        if (dut.state_q !== IDLE || char_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got state %0d valid %b expected %0d 0",
                     dut.state_q, char_out_valid, IDLE);
        end
        rst_in = 1'b1;
        tick(2 * BT);
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL midrst_idle: got %0d expected %0d",
                     dut.state_q, IDLE);
        end
        for (int i = 0; i < 3; i++) send_byte(exp_q[i], 1'b1, 1'b0, c0);
        tick(8);
        checks++;
        if (got_data.size() - bp !== 3) begin
            errors++;
            $display("FAIL midrst_count: got %0d expected 3",
                     got_data.size() - bp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_data.size() <= bp + i || got_data[bp + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_data_%0d: got %h expected %h", i,
                         (got_data.size() > bp + i) ? got_data[bp + i] : 8'hxx,
                         exp_q[i]);
            end
        end
        checks++;
        if (ferr_hi - bf !== 0) begin
            errors++;
            $display("FAIL midrst_ferr: got %0d expected 0", ferr_hi - bf);
        end
    endtask

    initial begin
        rst_in = 1'b0;
        rx_in = 1'b1;
        char_out_ready = 1'b0;
        test_reset();
        test_single_char();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_char_rx.md
UART_CHAR_RX -- requirements
Module: uart_char_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16, received-byte buffer depth; power of two, at least 2.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-low reset.
REQ-006 rx_in  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 char_out  output  8  head-of-buffer byte, fed to the UCI command parser's char input.
REQ-008 char_out_valid  output  1  high whenever the buffer is non-empty.
REQ-009 char_out_ready  input  1  consumer accepts char_out when high together with char_out_valid.
REQ-010 frame_err_out  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overflow_out  output  1  one-cycle pulse when a received byte is dropped because the buffer is full.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer, reset to 1; all decoding uses the synchronized signal.
REQ-013 BIT_TICKS = CLK_HZ/BAUD and HALF_TICKS = BIT_TICKS/2 (both truncating); the tick counter SHALL be wide enough for BIT_TICKS-1.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE -> START when the synchronized line is 0; the counter loads 0.
REQ-016 START: after HALF_TICKS cycles, a line reading of 0 -> DATA with bit index 0; a reading of 1 -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: sample every BIT_TICKS cycles into bit[index], LSB first; after index 7 is sampled -> STOP.
REQ-018 STOP: sample once after BIT_TICKS cycles.
  - Line 1: push the byte and return to IDLE.
  - Line 0: pulse frame_err_out, discard the byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH -> IDLE only once the synchronized line reads 1.
REQ-020 The buffer SHALL be a first-word-fall-through FIFO. char_out and char_out_valid reflect the head combinationally from registered storage and pointers.
REQ-021 A pushed byte SHALL appear on char_out with char_out_valid high on the cycle after the push edge (1-cycle latency).
REQ-022 Pop occurs on a cycle with char_out_valid && char_out_ready; char_out_ready while empty has no effect.
REQ-023 Push and pop in the same cycle SHALL both take effect at any occupancy, including full (count unchanged, no overflow).
REQ-024 Push while full with no pop SHALL drop the new byte, pulse overflow_out, and leave contents and pointers unchanged.
REQ-025 Read and write pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-026 Receiver timing SHALL NOT depend on consumer backpressure; reception continues while the FIFO is full.

Reset
REQ-027 While rst_in=0 at a clock edge, the block SHALL load:
  - FSM = IDLE; counter, bit index and shift register = 0; synchronizer flops = 1.
  - FIFO emptied.
  - char_out_valid, frame_err_out and overflow_out = 0.
REQ-028 Reset mid-frame SHALL abandon the frame. After release the receiver waits in IDLE for a new falling edge; a partial byte is never pushed.

Structure
REQ-029 The shared package SHALL hold the uart_rx_state enum and a function computing BIT_TICKS from CLK_HZ and BAUD.
REQ-030 The FIFO SHALL be a separate sub-module, byte_fifo, parameterized by DEPTH, with the same valid/ready semantics and the same synchronous active-low reset.

Verification (CLK_HZ=100e6, BAUD=115200, BIT_TICKS=868, FIFO_DEPTH=16)
REQ-031 Send 0x67 ('g'), consumer ready -> char_out=0x67 with char_out_valid high for exactly 1 cycle, starting within 1 cycle after the mid-stop sample; no error pulses.
REQ-032 Hold rx_in low for 300 cycles, then high -> no byte pushed, no pulses, FSM back in IDLE.
REQ-033 Send 0x55 with stop bit low, then line high -> frame_err_out pulses once, FIFO stays empty; a following 0x0A is received correctly.
REQ-034 Consumer not ready; send 17 bytes 0x00..0x10 -> overflow_out pulses once, on the 17th byte; draining yields 0x00..0x0F in order, then char_out_valid=0.
REQ-035 FIFO full, then assert char_out_ready on the cycle a new byte 0x41 is pushed -> no overflow; count stays 16; 0x41 is last when drained.
REQ-036 Drive rst_in low at data bit 4 of 0x70, then release, then send "go\n" -> exactly 0x67, 0x6F, 0x0A delivered.
